// File: rtl/bcd_digit_adder.sv
// Registered packed-BCD adder: NDIGITS digits plus carry-in, one-cycle latency.
// Optional BCD_INPUT_CHECK_EN adds a registered err flag for non-BCD input digits.
module bcd_digit_adder #(
    parameter int NDIGITS = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [4*NDIGITS-1:0]   A,
    input  logic [4*NDIGITS-1:0]   B,
    input  logic                   Cin,
    output logic [4*NDIGITS-1:0]   Sum,
    output logic                   Cout,
`ifdef BCD_INPUT_CHECK_EN
    output logic                   out_valid,
    output logic                   err
`else
    output logic                   out_valid
`endif
);

    // Handshake: a result is produced one cycle after every in_valid edge and
    // is present (out_valid=1) for exactly that one cycle; there is no ready.

    logic [4*NDIGITS-1:0] sum_d, sum_q;
    logic                 cout_d, cout_q;
    logic                 valid_q;

    // Decimal ripple: each digit adds in binary and, above 9, adds 6 to wrap
    // into the next decade, forwarding a carry to the digit above.
    always_comb begin
        logic       carry;
        logic [4:0] s;
        logic [4:0] s_adj;
        sum_d = '0;
        carry = Cin;
        for (int i = 0; i < NDIGITS; i++) begin
            s     = {1'b0, A[4*i +: 4]} + {1'b0, B[4*i +: 4]} + {4'b0000, carry};
            s_adj = s + 5'd6;
            if (s > 5'd9) begin
                sum_d[4*i +: 4] = s_adj[3:0];
                carry           = 1'b1;
            end else begin
                sum_d[4*i +: 4] = s[3:0];
                carry           = 1'b0;
            end
        end
        cout_d = carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign out_valid = valid_q;

`ifdef BCD_INPUT_CHECK_EN
    logic err_d, err_q;

    always_comb begin
        err_d = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if ((A[4*i +: 4] > 4'd9) || (B[4*i +: 4] > 4'd9)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (in_valid) begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_bcd_digit_adder.sv
// Self-checking bench for bcd_digit_adder (two digits), scoreboard-based.
// Compiles with or without BCD_INPUT_CHECK_EN; err is checked only when present.
module tb_bcd_digit_adder;

    localparam int ND = 2;
    localparam int DW = 4 * ND;
    localparam int W  = DW + 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic          Cin;
    logic [DW-1:0] Sum;
    logic          Cout;
    logic          out_valid;
    logic          err_obs;

    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  sb_exp;
    logic [W-1:0]  sb_obs;
    int            n_tests;
    int            n_fail;
    int            n_seen;

`ifdef BCD_INPUT_CHECK_EN
    logic err;
    assign err_obs = err;
`else
    assign err_obs = 1'b0;
`endif

    bcd_digit_adder #(.NDIGITS(ND)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sum       (Sum),
        .Cout      (Cout),
`ifdef BCD_INPUT_CHECK_EN
        .out_valid (out_valid),
        .err       (err)
`else
        .out_valid (out_valid)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs {err, cout, sum}; err is forced to 0 when the port does not exist.
    function automatic logic [W-1:0] mk(input logic e, input logic c, input logic [DW-1:0] s);
`ifdef BCD_INPUT_CHECK_EN
        return {e, c, s};
`else
        return {e & 1'b0, c, s};
`endif
    endfunction

    // Reference: true decimal addition for valid BCD, digit-wise rule otherwise.
    function automatic logic [W-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic cin);
        logic          bad;
        logic          c;
        logic [DW-1:0] s;
        int            va, vb, tot, p, t;
        bad = 1'b0;
        s   = '0;
        for (int i = 0; i < ND; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        if (!bad) begin
            va = 0; vb = 0; p = 1;
            for (int i = 0; i < ND; i++) begin
                va += int'(a[4*i +: 4]) * p;
                vb += int'(b[4*i +: 4]) * p;
                p  *= 10;
            end
            tot = va + vb + int'(cin);
            c   = (tot >= p);
            tot = tot % p;
            for (int i = 0; i < ND; i++) begin
                s[4*i +: 4] = 4'(tot % 10);
                tot /= 10;
            end
        end else begin
            c = cin;
            for (int i = 0; i < ND; i++) begin
                t = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + int'(c);
                if (t > 9) begin
                    s[4*i +: 4] = 4'((t + 6) % 16);
                    c = 1'b1;
                end else begin
                    s[4*i +: 4] = 4'(t);
                    c = 1'b0;
                end
            end
        end
        return mk(bad, c, s);
    endfunction

    // Driver tasks
    task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cin,
                         input logic [W-1:0] e);
        @(negedge clk);
        A        = a;
        B        = b;
        Cin      = cin;
        in_valid = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        A        = DW'($urandom);
        B        = DW'($urandom);
        Cin      = 1'($urandom);
    endtask

    // Scoreboard: every out_valid cycle must match the oldest pending expectation.
    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) begin
            n_tests++;
            n_seen++;
            sb_obs = {err_obs, Cout, Sum};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got {err,cout,sum}=%h, expected no output", sb_obs);
            end else begin
                sb_exp = exp_q.pop_front();
                if (sb_obs !== sb_exp) begin
                    n_fail++;
                    $display("FAIL sb_result: got {err,cout,sum}=%h, expected %h", sb_obs, sb_exp);
                end
            end
        end
    end

    task automatic test_reset();
        #2;
        n_tests++;
        if ({err_obs, Cout, Sum, out_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_in: got err=%b cout=%b sum=%h ov=%b, expected all 0",
                     err_obs, Cout, Sum, out_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({err_obs, Cout, Sum, out_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_after: got err=%b cout=%b sum=%h ov=%b, expected all 0",
                     err_obs, Cout, Sum, out_valid);
        end
    endtask

    task automatic test_basic();
        drive(8'h00, 8'h00, 1'b0, mk(1'b0, 1'b0, 8'h00));
        drive(8'h05, 8'h06, 1'b0, mk(1'b0, 1'b0, 8'h11));
        drive(8'h09, 8'h09, 1'b1, mk(1'b0, 1'b0, 8'h19));
        drive(8'h03, 8'h04, 1'b0, mk(1'b0, 1'b0, 8'h07));
        idle();
        // Inputs change randomly while in_valid is low; outputs must hold.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_tests++;
            if (Sum !== 8'h07 || Cout !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d: got sum=%h cout=%b ov=%b, expected sum=07 cout=0 ov=0",
                         k, Sum, Cout, out_valid);
            end
            idle();
        end
    endtask

    task automatic test_ripple();
        drive(8'h99, 8'h01, 1'b0, mk(1'b0, 1'b1, 8'h00));
        drive(8'h99, 8'h99, 1'b1, mk(1'b0, 1'b1, 8'h99));
        drive(8'h45, 8'h54, 1'b1, mk(1'b0, 1'b1, 8'h00));
        drive(8'h50, 8'h49, 1'b0, mk(1'b0, 1'b0, 8'h99));
        drive(8'h08, 8'h02, 1'b0, mk(1'b0, 1'b0, 8'h10));
        idle();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a, b;
        logic          c;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < ND; i++) begin
                a[4*i +: 4] = 4'($urandom_range(9));
                b[4*i +: 4] = 4'($urandom_range(9));
            end
            c = 1'($urandom_range(1));
            drive(a, b, c, model(a, b, c));
        end
        idle();
    endtask

    task automatic test_invalid_digits();
        logic [DW-1:0] a, b;
        logic          c;
        drive(8'h0A, 8'h00, 1'b0, mk(1'b1, 1'b0, 8'h10));
        drive(8'hF0, 8'h00, 1'b0, mk(1'b1, 1'b1, 8'h50));
        for (int k = 0; k < 12; k++) begin
            a = DW'($urandom);
            b = DW'($urandom);
            c = 1'($urandom_range(1));
            drive(a, b, c, model(a, b, c));
        end
        drive(8'h12, 8'h34, 1'b0, mk(1'b0, 1'b0, 8'h46));
        idle();
    endtask

    task automatic test_reset_mid();
        drive(8'h12, 8'h34, 1'b1, mk(1'b0, 1'b0, 8'h47));
        @(posedge clk); #3;
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got ov=%b, expected 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({err_obs, Cout, Sum, out_valid} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got err=%b cout=%b sum=%h ov=%b, expected all 0",
                     err_obs, Cout, Sum, out_valid);
        end
        // Operands presented while reset is held are discarded.
        @(negedge clk);
        A = 8'h55; B = 8'h44; Cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({err_obs, Cout, Sum, out_valid} !== '0) begin
            n_fail++;
            $display("FAIL rst_hold: got err=%b cout=%b sum=%h ov=%b, expected all 0",
                     err_obs, Cout, Sum, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        A = 8'h21; B = 8'h21; Cin = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 8'h43));
        idle();
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        n_seen   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        Cin      = 1'b0;

        test_reset();
        test_basic();
        test_ripple();
        test_back_to_back();
        test_invalid_digits();
        test_reset_mid();

        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d results missing (%0d seen), expected 0 missing",
                     exp_q.size(), n_seen);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
